// File: rtl/adc_trig_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_trig_delay_line_if
// Brief    : Sample, latency, trigger and window signals of the ADC delay line
// Revision : 1.0 - initial release
// ============================================================================
interface adc_trig_delay_line_if #(
  parameter int NCH      = 64,
  parameter int ADC_BITS = 12,
  parameter int DEPTH    = 64,
  parameter int WLW      = 8
);
  localparam int DW = NCH * ADC_BITS;
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]  din_i;
  logic [AW-1:0]  lat_i;
  logic [WLW-1:0] win_len_i;
  logic           trig_i;
  logic [DW-1:0]  dout_o;
  logic           dout_valid_o;
  logic           win_o;
  logic           win_first_o;
  logic           win_last_o;
  logic           trig_lost_o;
  logic           lat_err_o;

  modport master (
    output din_i, lat_i, win_len_i, trig_i,
    input  dout_o, dout_valid_o, win_o, win_first_o, win_last_o, trig_lost_o, lat_err_o
  );

  modport slave (
    input  din_i, lat_i, win_len_i, trig_i,
    output dout_o, dout_valid_o, win_o, win_first_o, win_last_o, trig_lost_o, lat_err_o
  );
endinterface
`default_nettype wire

// File: rtl/adc_trig_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : adc_trig_delay_line
// Brief    : Circular-buffer trigger-latency delay with fill tracking and window marking
// Revision : 1.0 - initial release
// ============================================================================
module adc_trig_delay_line #(
  parameter int NCH      = 64,
  parameter int ADC_BITS = 12,
  parameter int DEPTH    = 64,
  parameter int WLW      = 8
) (
  input  logic                 adc_clk,
  input  logic                 rst_n,
  adc_trig_delay_line_if.slave bus
);
  localparam int DW = NCH * ADC_BITS;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAT_MAX  = AW'(DEPTH - 3);
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  dout;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  lat_q;
  logic [AW-1:0]  lat_clamp;
  logic [AW:0]    fill_cnt;
  logic           flush;
  logic           valid_nxt;
  logic           dout_valid;
  logic           lat_err;
  state_t         state;
  logic [WLW-1:0] win_cnt;
  logic           win;
  logic           win_first;
  logic           win_last;
  logic           trig_lost;
  logic           trig_ok;

  // The write on a flush edge is not counted, so valid starts with the first
  // sample whose read address was computed from the new latency.
  always_comb begin
    lat_clamp = (bus.lat_i > LAT_MAX) ? LAT_MAX : bus.lat_i;
    flush     = (lat_clamp != lat_q);
    valid_nxt = !flush && (fill_cnt > ({1'b0, lat_q} + (AW+1)'(1)));
    trig_ok   = bus.trig_i && (state == IDLE) && dout_valid &&
                (bus.win_len_i != '0) && !flush;
  end

  always_ff @(posedge adc_clk) begin
    mem[wr_ptr] <= bus.din_i;
    rd_data     <= mem[rd_ptr];
  end

  // Registered read pointer plus RAM read plus output register gives lat_q+2.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lat_q      <= '0;
      fill_cnt   <= '0;
      lat_err    <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(1);
      rd_ptr     <= wr_ptr - lat_q;
      lat_err    <= (bus.lat_i > LAT_MAX);
      if (flush) begin
        lat_q    <= lat_clamp;
        fill_cnt <= '0;
      end else if (fill_cnt != FILL_MAX) begin
        fill_cnt <= fill_cnt + (AW+1)'(1);
      end
      dout_valid <= valid_nxt;
      dout       <= valid_nxt ? rd_data : '0;
    end
  end

  // A trigger on a flush edge is rejected: the window would abort at once.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_cnt   <= '0;
      win       <= 1'b0;
      win_first <= 1'b0;
      win_last  <= 1'b0;
      trig_lost <= 1'b0;
    end else begin
      trig_lost <= bus.trig_i && !trig_ok;
      if (flush) begin
        state     <= IDLE;
        win       <= 1'b0;
        win_first <= 1'b0;
        win_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trig_ok) begin
              state     <= ACTIVE;
              win_cnt   <= bus.win_len_i;
              win       <= 1'b1;
              win_first <= 1'b1;
              win_last  <= (bus.win_len_i == WLW'(1));
            end
          end
          ACTIVE: begin
            win_first <= 1'b0;
            if (win_cnt == WLW'(1)) begin
              state    <= IDLE;
              win      <= 1'b0;
              win_last <= 1'b0;
            end else begin
              win_cnt  <= win_cnt - WLW'(1);
              win_last <= (win_cnt == WLW'(2));
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dout_o       = dout;
  assign bus.dout_valid_o = dout_valid;
  assign bus.win_o        = win;
  assign bus.win_first_o  = win_first;
  assign bus.win_last_o   = win_last;
  assign bus.trig_lost_o  = trig_lost;
  assign bus.lat_err_o    = lat_err;
endmodule
`default_nettype wire

// File: tb/tb_adc_trig_delay_line.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_adc_trig_delay_line
// Brief    : Scoreboard bench for adc_trig_delay_line with an edge-indexed reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_trig_delay_line;
  localparam int NCH      = 64;
  localparam int ADC_BITS = 12;
  localparam int DEPTH    = 64;
  localparam int WLW      = 8;
  localparam int DW       = NCH * ADC_BITS;
  localparam int LAT_MAX  = DEPTH - 3;

  typedef struct {
    logic [DW-1:0] dout;
    logic valid, win, first, last, lost, lerr;
  } exp_t;

  logic adc_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   fails   = 0;
  exp_t q[$];

  // Reference model: history of written samples indexed by edge number
  logic [DW-1:0] hist[$];
  int  m, m_lat, m_flush, w_start, w_end;
  bit  m_valid;
  bit  ramp;
  int  idx;

  adc_trig_delay_line_if #(.NCH(NCH), .ADC_BITS(ADC_BITS), .DEPTH(DEPTH), .WLW(WLW)) bus ();

  adc_trig_delay_line #(.NCH(NCH), .ADC_BITS(ADC_BITS), .DEPTH(DEPTH), .WLW(WLW)) dut (
    .adc_clk (adc_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_bus(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_zero();
    chk_bus("rst_dout", bus.dout_o, '0);
    chk("rst_dout_valid", bus.dout_valid_o, 1'b0);
    chk("rst_win", bus.win_o, 1'b0);
    chk("rst_win_first", bus.win_first_o, 1'b0);
    chk("rst_win_last", bus.win_last_o, 1'b0);
    chk("rst_trig_lost", bus.trig_lost_o, 1'b0);
    chk("rst_lat_err", bus.lat_err_o, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd_din();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    m = 0; m_lat = 0; m_flush = -1; w_start = -1; w_end = -1; m_valid = 0;
  endtask

  // Called at the active edge with the inputs the DUT samples on that edge.
  task automatic model_edge();
    exp_t x;
    int   lat_c, e;
    bit   fl, act, acc;
    lat_c = (int'(bus.lat_i) > LAT_MAX) ? LAT_MAX : int'(bus.lat_i);
    hist.push_back(bus.din_i);
    fl  = (lat_c != m_lat);
    act = (w_start >= 0) && (m-1 >= w_start) && (m-1 <= w_end);
    acc = bus.trig_i && !act && m_valid && (bus.win_len_i != 0) && !fl;
    if (fl) begin
      m_lat = lat_c;
      m_flush = m;
      if (act) w_end = m - 1;
    end
    if (acc) begin
      w_start = m;
      w_end   = m + int'(bus.win_len_i) - 1;
    end
    e       = m - m_lat - 2;
    x.valid = (e > m_flush);
    x.dout  = x.valid ? hist[e] : '0;
    x.win   = (w_start >= 0) && (m >= w_start) && (m <= w_end);
    x.first = x.win && (m == w_start);
    x.last  = x.win && (m == w_end);
    x.lost  = bus.trig_i && !acc;
    x.lerr  = (int'(bus.lat_i) > LAT_MAX);
    m_valid = x.valid;
    q.push_back(x);
    m++;
  endtask

  task automatic cyc(input logic t);
    bus.trig_i = t;
    bus.din_i  = rnd_din();
    if (ramp) bus.din_i[ADC_BITS-1:0] = ADC_BITS'(idx);
    idx++;
    @(posedge adc_clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n, input int prob);
    for (int i = 0; i < n; i++)
      cyc((prob != 0) && ($urandom_range(0, prob-1) == 0));
  endtask

  always @(negedge adc_clk) begin
    exp_t x;
    if (q.size() != 0) begin
      x = q.pop_front();
      chk("dout_valid", bus.dout_valid_o, x.valid);
      chk_bus("dout", bus.dout_o, x.dout);
      chk("win", bus.win_o, x.win);
      chk("win_first", bus.win_first_o, x.first);
      chk("win_last", bus.win_last_o, x.last);
      chk("trig_lost", bus.trig_lost_o, x.lost);
      chk("lat_err", bus.lat_err_o, x.lerr);
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.din_i = '0; bus.lat_i = '0; bus.win_len_i = '0; bus.trig_i = 1'b0;
    ramp = 1; idx = 0;
    repeat (3) @(posedge adc_clk);
    #1 chk_zero();
    bus.lat_i = 10; bus.win_len_i = 4;
    rst_n = 1'b1;
    model_reset();

    // Ramp at latency 10, with an early trigger before the buffer fills
    run(3, 0); cyc(1); run(60, 0);

    // Maximum legal latency across several pointer wraps
    ramp = 0;
    bus.lat_i = LAT_MAX; bus.win_len_i = 6;
    run(3*DEPTH, 16);

    // Out-of-range latency clamps to the same value, no flush
    bus.lat_i = 63;
    run(100, 16);

    // Latency change mid-stream
    bus.lat_i = 10; run(40, 0);
    bus.lat_i = 20; run(60, 0);

    // Directed window with a second trigger inside it, then a length-1 window
    bus.lat_i = 5; bus.win_len_i = 4;
    run(20, 0);
    cyc(1); cyc(0); cyc(1); run(10, 0);
    bus.win_len_i = 1;
    cyc(1); run(5, 0);
    bus.win_len_i = 0;
    cyc(1); run(3, 0);

    // Reset asserted while a window is open
    bus.win_len_i = 20;
    cyc(1); run(3, 0);
    #1 rst_n = 1'b0;
    q.delete();
    #1 chk_zero();
    @(posedge adc_clk);
    @(posedge adc_clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Random latencies, lengths and triggers
    for (int b = 0; b < 8; b++) begin
      bus.lat_i     = 6'($urandom_range(0, DEPTH-1));
      bus.win_len_i = 8'($urandom_range(0, 12));
      cyc(0);
      run(60, 6);
    end

    @(negedge adc_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
